// File: rtl/serial_tx_fifo_if.sv
// Handshake bundle between the producer/receiver side and serial_tx_fifo.
// The master modport is the environment. The slave modport is the transmitter.
interface serial_tx_fifo_if #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 8
);
  logic             en;
  logic             req;
  logic [WIDTH-1:0] parallel_in;
  logic             channel_busy;
  logic             tx_busy;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             frame_done;
  logic             serial_out;

  modport master (
    output en, req, parallel_in, channel_busy,
    input  tx_busy, fifo_count, overflow, frame_done, serial_out
  );

  modport slave (
    input  en, req, parallel_in, channel_busy,
    output tx_busy, fifo_count, overflow, frame_done, serial_out
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// Buffered serial transmitter. Items are queued in a FIFO and sent as frames:
// a start bit, then LSB-first data, then an idle gap.
//
// state | meaning
// IDLE  | line low; waits for en, a queued item and a free channel
// START | start bit (line high) for one cycle
// DATA  | shifting the payload out LSB first, WIDTH cycles
// GAP   | line low for GAP_CYCLES; frame_done on the last cycle
module serial_tx_fifo #(
  parameter int WIDTH      = 40,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  serial_tx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_busy_q, overflow_q;
  logic             frame_done_q, frame_done_d;
  logic             serial_q, serial_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             push, pop;

  // tx_busy is registered, so a push while full is refused even if a pop
  // happens in the same cycle.
  assign push    = bus.req && !tx_busy_q;
  assign pop     = (state_q == IDLE) && bus.en && (count_q != '0) && !bus.channel_busy;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.parallel_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_busy_q    <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      serial_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      tx_busy_q    <= (count_d == CNT_W'(DEPTH));
      overflow_q   <= bus.req && tx_busy_q;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      serial_q     <= serial_d;
      frame_done_q <= frame_done_d;
    end
  end

  // serial_d is the line level for the state being entered, so the line
  // changes on the same edge as the state.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    serial_d     = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d  = START;
          shift_d  = mem[rd_ptr_q];
          serial_d = 1'b1;
        end
      end
      START: begin
        state_d  = DATA;
        bit_d    = '0;
        serial_d = shift_q[0];
      end
      DATA: begin
        if (bit_q == BIT_W'(WIDTH - 1)) begin
          state_d      = GAP;
          gap_d        = GAP_W'(GAP_CYCLES - 1);
          frame_done_d = (GAP_CYCLES == 1);
        end else begin
          bit_d    = bit_q + BIT_W'(1);
          shift_d  = shift_q >> 1;
          serial_d = shift_q[1];
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d        = gap_q - GAP_W'(1);
          frame_done_d = (gap_q == GAP_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_busy    = tx_busy_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.frame_done = frame_done_q;
  assign bus.serial_out = serial_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo. Outputs are sampled on the falling
// edge, and inputs are also driven on the falling edge.
module tb_serial_tx_fifo;
  localparam int WIDTH = 40;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_tx_fifo_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  serial_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [WIDTH-1:0] d);
    bus.req = 1'b1;
    bus.parallel_in = d;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  // Waits a bounded time for a start bit, then captures payload and gap.
  // If busy_bit >= 0, channel_busy is raised right after that data bit is sampled.
  task automatic grab_frame(input int busy_bit, output logic [WIDTH-1:0] d, output int wait_n,
                            output logic gap_ok, output int fd_n, output logic fd_last);
    d = 'x; wait_n = -1; gap_ok = 1'b0; fd_n = 0; fd_last = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.serial_out === 1'b1) begin
        wait_n = w;
        break;
      end
    end
    if (wait_n < 0) return;
    for (int b = 0; b < WIDTH; b++) begin
      @(negedge clk);
      d[b] = bus.serial_out;
      if (bus.frame_done === 1'b1) fd_n++;
      if (b == busy_bit) bus.channel_busy = 1'b1;
    end
    gap_ok = 1'b1;
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      if (bus.serial_out !== 1'b0) gap_ok = 1'b0;
      if (bus.frame_done === 1'b1) fd_n++;
      fd_last = bus.frame_done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_cmp++; if (bus.serial_out !== 1'b0) begin n_err++; $display("FAIL reset_serial: got %b want 0", bus.serial_out); end
    n_cmp++; if (bus.tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_tx_busy: got %b want 0", bus.tx_busy); end
    n_cmp++; if (bus.fifo_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] d; int wn; logic gk; int fn; logic fl;
    bus.en = 1'b1; bus.channel_busy = 1'b0;
    push(40'h00_0000_00A5);
    grab_frame(-1, d, wn, gk, fn, fl);
    n_cmp++; if (wn !== 0) begin n_err++; $display("FAIL single_latency: start after %0d extra cycles, want 0", wn); end
    n_cmp++; if (d !== 40'h00_0000_00A5) begin n_err++; $display("FAIL single_data: got %h want 00000000a5", d); end
    n_cmp++; if (gk !== 1'b1) begin n_err++; $display("FAIL single_gap: gap low got %b want 1", gk); end
    n_cmp++; if (fn !== 1 || fl !== 1'b1) begin n_err++; $display("FAIL single_frame_done: pulses %0d last %b want 1 1", fn, fl); end
    @(negedge clk);
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL single_fd_clear: got %b want 0", bus.frame_done); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d[5]; int wn[5]; logic gk[5]; int fn[5]; logic fl[5];
    logic [CNT_W-1:0] cnt[5];
    int exp_cnt[5] = '{1, 1, 2, 3, 4};
    bus.en = 1'b1; bus.channel_busy = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          bus.req = 1'b1;
          bus.parallel_in = WIDTH'(k + 1);
          @(negedge clk);
          cnt[k] = bus.fifo_count;
        end
        bus.req = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) grab_frame(-1, d[k], wn[k], gk[k], fn[k], fl[k]);
      end
    join
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (cnt[k] !== CNT_W'(exp_cnt[k])) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, cnt[k], exp_cnt[k]); end
      n_cmp++; if (d[k] !== WIDTH'(k + 1)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, d[k], WIDTH'(k + 1)); end
      n_cmp++; if (gk[k] !== 1'b1 || fn[k] !== 1 || fl[k] !== 1'b1) begin n_err++; $display("FAIL b2b_gap[%0d]: gap %b pulses %0d last %b want 1 1 1", k, gk[k], fn[k], fl[k]); end
      if (k > 0) begin
        n_cmp++; if (wn[k] !== 1) begin n_err++; $display("FAIL b2b_idle[%0d]: idle cycles %0d want 1", k, wn[k]); end
      end
    end
    n_cmp++; if (bus.fifo_count !== 8'd0) begin n_err++; $display("FAIL b2b_drained: got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] d; int wn; logic gk; int fn; logic fl; logic quiet;
    bus.en = 1'b1; bus.channel_busy = 1'b1;
    for (int k = 0; k < 8; k++) push(WIDTH'(32'h100 + k));
    n_cmp++; if (bus.tx_busy !== 1'b1) begin n_err++; $display("FAIL ovf_full: tx_busy got %b want 1", bus.tx_busy); end
    n_cmp++; if (bus.fifo_count !== 8'd8) begin n_err++; $display("FAIL ovf_count8: got %0d want 8", bus.fifo_count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
    push(40'h00_0000_01FF);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow); end
    n_cmp++; if (bus.fifo_count !== 8'd8) begin n_err++; $display("FAIL ovf_count_hold: got %0d want 8", bus.fifo_count); end
    @(negedge clk);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle: got %b want 0", bus.overflow); end
    bus.channel_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      grab_frame(-1, d, wn, gk, fn, fl);
      n_cmp++; if (d !== WIDTH'(32'h100 + k)) begin n_err++; $display("FAIL ovf_data[%0d]: got %h want %h", k, d, WIDTH'(32'h100 + k)); end
    end
    quiet = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.serial_out !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL ovf_ninth_sent: line went high, want quiet"); end
    n_cmp++; if (bus.fifo_count !== 8'd0 || bus.tx_busy !== 1'b0) begin n_err++; $display("FAIL ovf_empty: count %0d busy %b want 0 0", bus.fifo_count, bus.tx_busy); end
  endtask

  task automatic test_busy_mid_frame();
    logic [WIDTH-1:0] d; int wn; logic gk; int fn; logic fl; logic quiet;
    bus.en = 1'b0; bus.channel_busy = 1'b0;
    push(40'h12_3456_789A);
    push(40'hC3_5A5A_0F0F);
    bus.en = 1'b1;
    grab_frame(10, d, wn, gk, fn, fl);
    n_cmp++; if (d !== 40'h12_3456_789A) begin n_err++; $display("FAIL busy_frame_a: got %h want 123456789a", d); end
    n_cmp++; if (gk !== 1'b1 || fn !== 1 || fl !== 1'b1) begin n_err++; $display("FAIL busy_frame_a_end: gap %b pulses %0d last %b want 1 1 1", gk, fn, fl); end
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.serial_out !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL busy_hold: line went high while channel busy"); end
    n_cmp++; if (bus.fifo_count !== 8'd1) begin n_err++; $display("FAIL busy_count: got %0d want 1", bus.fifo_count); end
    bus.channel_busy = 1'b0;
    grab_frame(-1, d, wn, gk, fn, fl);
    n_cmp++; if (d !== 40'hC3_5A5A_0F0F) begin n_err++; $display("FAIL busy_frame_b: got %h want c35a5a0f0f", d); end
  endtask

  task automatic test_en_gate();
    logic [WIDTH-1:0] d; int wn; logic gk; int fn; logic fl; logic quiet;
    logic [WIDTH-1:0] items[3] = '{40'h00_0000_0011, 40'h80_0000_0001, 40'h55_AA55_AA55};
    bus.en = 1'b0; bus.channel_busy = 1'b0;
    for (int k = 0; k < 3; k++) push(items[k]);
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.serial_out !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL en_hold: line went high with en=0"); end
    n_cmp++; if (bus.fifo_count !== 8'd3) begin n_err++; $display("FAIL en_count: got %0d want 3", bus.fifo_count); end
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      grab_frame(-1, d, wn, gk, fn, fl);
      n_cmp++; if (d !== items[k]) begin n_err++; $display("FAIL en_data[%0d]: got %h want %h", k, d, items[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [WIDTH-1:0] d; int wn; logic gk; int fn; logic fl; logic quiet; logic seen;
    bus.en = 1'b0; bus.channel_busy = 1'b0;
    for (int k = 0; k < 3; k++) push(40'hFF_FFFF_FFFF);
    bus.en = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.serial_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rst_mid_start: no start bit seen"); end
    repeat (21) @(negedge clk);
    n_cmp++; if (bus.serial_out !== 1'b1) begin n_err++; $display("FAIL rst_mid_bit20: got %b want 1", bus.serial_out); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.serial_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_serial: got %b want 0", bus.serial_out); end
    n_cmp++; if (bus.fifo_count !== 8'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d want 0", bus.fifo_count); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.serial_out !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL rst_mid_quiet: frame sent after reset without push"); end
    push(40'h0F_1E2D_3C4B);
    grab_frame(-1, d, wn, gk, fn, fl);
    n_cmp++; if (d !== 40'h0F_1E2D_3C4B) begin n_err++; $display("FAIL rst_mid_new: got %h want 0f1e2d3c4b", d); end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.parallel_in = '0;
    bus.channel_busy = 1'b0;
    bus.en = 1'b1;
    reset = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_busy_mid_frame();
    test_en_gate();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
